alu_seq: RTL
============

Name: alu_seq

Overview:
- Arithmetic stage directly downstream of the A and B registers. It consumes the A-register value and the B-register add_sub output.
- On a start pulse it latches both operands and executes ADD, SUB, CMP or an 8-cycle shift-add MUL.
- It holds the result and C/Z/N/V flags in registers and drives the result onto the 8-bit bus through a tri-state buffer when Eu is high.
- Flags feed the controller for conditional jumps.

Parameters:
- WIDTH, 8, operand/result width (only 8 is verified).
- MUL_CYCLES, WIDTH, shift-add iterations for MUL; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  synchronous active-low reset.
- a_in  input  8  operand A, from the A register.
- b_in  input  8  operand B, from the B register add_sub output.
- op  input  2  00 ADD, 01 SUB (a-b), 10 MUL, 11 CMP.
- start  input  1  one-cycle request; sampled only in IDLE.
- Eu  input  1  bus output enable.
- bus_out  output  8  result when Eu=1, else 8'hz.
- prod_hi  output  8  upper byte of last MUL product.
- busy  output  1  high in EXEC and MUL states.
- done  output  1  high for exactly one cycle (DONE state).
- cf, zf, nf, vf  output  1 each  carry/borrow, zero, negative, signed overflow.

Behaviour:
- Reset: clr_n=0 at a rising edge does the following, regardless of state, including mid-MUL (MUL aborts, no done pulse):
  - State goes to IDLE.
  - result, prod_hi, cf, zf, nf, vf, counter and latched operands all go to 0.
  - busy=0, done=0.
- bus_out is combinational: Eu ? result : 8'hz. It is independent of FSM state and shows the held result, even mid-operation.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE: start=1 at edge k latches a_in, b_in and op. Go to MUL if op=10, else EXEC.
  - EXEC: at edge k+1 write result/flags, go to DONE.
  - MUL: counter 0..7. Each edge adds the shifted multiplicand when the multiplier LSB is 1, then shifts. At edge k+8 write the 16-bit product (low byte to result, high byte to prod_hi) and flags, go to DONE.
  - DONE: done=1 for one cycle; next edge returns to IDLE.
- start outside IDLE is ignored (not queued). Operand changes after edge k have no effect.
- Minimum start-to-start spacing: 3 cycles for ADD/SUB/CMP, 10 cycles for MUL.
- ADD: result = (a+b) mod 256; cf = bit-8 carry; vf = signed overflow.
- SUB: result = (a-b) mod 256; cf = borrow (1 iff a<b unsigned); vf = signed overflow of a-b.
- CMP: flags computed exactly as SUB; result and prod_hi unchanged.
- All ops: zf = (8-bit result==0), nf = result bit7.
- MUL flags: zf = (16-bit product==0); nf=0; vf=0; cf = (prod_hi!=0).
- ADD/SUB/CMP leave prod_hi unchanged.
- Flags and result are stable between operations, and change only at the completing edge.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL state and shift-add datapath are present, as above.
- Undefined:
  - MUL state and datapath are not built; prod_hi is tied to 0.
  - op=10 goes IDLE->EXEC->DONE with result and flags unchanged; done still pulses at k+2.

Test Plan:
- ADD 8'h7F+8'h01 -> result=8'h80, cf=0, zf=0, nf=1, vf=1; done high exactly one cycle, 2 edges after start; Eu=1 shows 8'h80 on bus_out, Eu=0 gives 8'hz.
- SUB 8'h05-8'h07 -> result=8'hFE, cf=1, nf=1, vf=0. Then CMP 8'h10,8'h10 -> zf=1, cf=0, result still 8'hFE.
- MUL (ALU_MUL_EN) 8'hC8*8'h0F -> after 8 busy edges: result=8'hB8, prod_hi=8'h0B, cf=1, zf=0; done 9 edges after start.
- Pulse start with op=ADD during MUL busy -> ignored; MUL completes with the original product, exactly one done pulse.
- clr_n=0 at the 4th edge of a MUL -> next cycle busy=0, done=0, result=0, prod_hi=0, all flags 0; no done pulse follows.
- Without ALU_MUL_EN, op=10 with a prior result 8'h55 -> result stays 8'h55, flags unchanged, done at k+2.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequenced arithmetic stage fed by the A and B registers.
//
// When start arrives in IDLE, the block latches both operands and the opcode.
// It then runs ADD / SUB / CMP in a single EXEC cycle, or an 8-step
// shift-add MUL. The result, the upper product byte and the C/Z/N/V flags are
// held in registers. They change only on the edge that completes an operation.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : MUL state and shift-add datapath are built.
//   undefined : no multiplier. prod_hi is tied to 0, and op=10 passes through
//               EXEC -> DONE without changing the result or the flags.
//
// Ports:
//   clk        system clock, rising edge
//   clr_n      synchronous active-low reset
//   a_in/b_in  operands (latched on the start edge)
//   op         00 ADD, 01 SUB (a-b), 10 MUL, 11 CMP
//   start      one-cycle request, honoured only in IDLE
//   Eu         bus output enable
//   bus_out    held result when Eu=1, otherwise high impedance
//   prod_hi    upper byte of the last MUL product
//   busy       high in EXEC and MUL
//   done       one-cycle completion pulse (DONE state)
//   cf/zf/nf/vf carry-borrow, zero, negative, signed overflow
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start; operands latched on start
// EXEC   | single-cycle ADD/SUB/CMP (and MUL when disabled)
// MUL    | shift-add iterations, counter 0..MUL_CYCLES-1
// DONE   | done pulse, back to IDLE on the next edge

module alu_seq #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             Eu,
  output logic [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] prod_hi,
  output logic             busy,
  output logic             done,
  output logic             cf,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             nf_q, nf_d;
  logic             vf_q, vf_d;

  // One extra bit on the sum and the difference carries the carry/borrow out.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w  = {1'b0, a_q} - {1'b0, b_q};
  // Add overflows when both operands share a sign that the sum does not.
  assign add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
  // Subtract overflows when the operand signs differ and the result takes b's sign.
  assign sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);

`ifdef ALU_MUL_EN
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam int         CW     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_sum;

  // This is the partial product for the current step. It includes the addition
  // being made on this edge, so the last iteration can commit it directly.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_hi = prod_hi_q;
`else
  assign prod_hi = '0;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    vf_d     = vf_q;
`ifdef ALU_MUL_EN
    prod_hi_d = prod_hi_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d  = a_in;
          b_d  = b_in;
          op_d = op;
          state_d = S_EXEC;
`ifdef ALU_MUL_EN
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_in};
            mplier_d = b_in;
          end
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_d = sum_w[WIDTH-1:0];
            cf_d     = sum_w[WIDTH];
            zf_d     = (sum_w[WIDTH-1:0] == '0);
            nf_d     = sum_w[WIDTH-1];
            vf_d     = add_ovf;
          end
          OP_SUB, OP_CMP: begin
            if (op_q == OP_SUB) result_d = diff_w[WIDTH-1:0];
            cf_d = diff_w[WIDTH];
            zf_d = (diff_w[WIDTH-1:0] == '0);
            nf_d = diff_w[WIDTH-1];
            vf_d = sub_ovf;
          end
          // When the multiplier is not built, op=10 lands here and changes nothing.
          default: ;
        endcase
        state_d = S_DONE;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 1)) begin
          result_d  = acc_sum[WIDTH-1:0];
          prod_hi_d = acc_sum[2*WIDTH-1:WIDTH];
          cf_d      = (acc_sum[2*WIDTH-1:WIDTH] != '0);
          zf_d      = (acc_sum == '0);
          nf_d      = 1'b0;
          vf_d      = 1'b0;
          state_d   = S_DONE;
        end
      end
`else
      S_MUL: state_d = S_IDLE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      vf_q     <= 1'b0;
`ifdef ALU_MUL_EN
      prod_hi_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      vf_q     <= vf_d;
`ifdef ALU_MUL_EN
      prod_hi_q <= prod_hi_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
`endif
    end
  end

  assign bus_out = Eu ? result_q : 'z;
  assign busy    = (state_q == S_EXEC) || (state_q == S_MUL);
  assign done    = (state_q == S_DONE);
  assign cf      = cf_q;
  assign zf      = zf_q;
  assign nf      = nf_q;
  assign vf      = vf_q;

endmodule
